ppu_mem_arbiter: RTL

Shares one single-ported ram256x8 between two requesters: the IF stage (instruction fetch, read-only, word) and the MEM stage (load/store, byte or word).
Sits between the pipeline's fetch/EX_MEM outputs and the RAM macro.
Grants one access at a time and holds it for a fixed latency. Gives MEM priority, with a starvation guard for IF.
Produces per-requester ack pulses and stall lines that gate the PC/IF_ID and EX_MEM/MEM_WB load enables.

---
 rtl/ppu_mem_pkg.sv | 18 +
 rtl/ppu_mem_arbiter_lat.sv | 35 +++
 rtl/ppu_mem_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ppu_mem_pkg.sv
// Shared types and constants for the IF/MEM arbiter in front of the ram256x8 macro.
package ppu_mem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2
    } arb_state_e;

    localparam logic RW_READ   = 1'b0;
    localparam logic RW_WRITE  = 1'b1;
    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

endpackage

// File: rtl/ppu_mem_arbiter_lat.sv
// Access-latency counter: loaded at each grant, counts down, flags the final BUSY cycle.
module arb_lat_counter #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic last_o
);

    localparam logic [2:0] LOAD_VAL = 3'(MEM_LAT - 1);

    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Zero both in the last BUSY cycle and while idle, so idle arbitration needs no extra term.
    assign last_o = (cnt_q == 3'd0);

endmodule

// File: rtl/ppu_mem_arbiter.sv
// Arbitrates one single-ported RAM between IF (word reads) and MEM (byte/word load/store).
// Optional grant/conflict statistics counters are built when PPU_ARB_STATS_EN is defined.
module ppu_mem_arbiter
    import ppu_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              R,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_rw,
    input  logic              mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              ram_E,
    output logic              ram_RW,
    output logic              ram_Size,
    output logic [ADDR_W-1:0] ram_A,
    output logic [DATA_W-1:0] ram_DI,
    input  logic [DATA_W-1:0] ram_DO
`ifdef PPU_ARB_STATS_EN
    ,
    output logic [15:0]       if_grant_cnt,
    output logic [15:0]       mem_grant_cnt,
    output logic [15:0]       conflict_cnt
`endif
);

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    arb_state_e        state_q, state_d;
    logic [2:0]        starve_q, starve_d;
    logic              if_ack_q, if_ack_d, mem_ack_q, mem_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
    logic              rw_q, rw_d, size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic last, arb, cand_if, cand_mem, grant_if, grant_mem, conflict;

    arb_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
        .clk    (clk),
        .rst_n  (R),
        .load_i (grant_if | grant_mem),
        .last_o (last)
    );

    // The requester finishing at this edge is not a candidate, so a held request cannot re-win instantly.
    always_comb begin
        arb       = (state_q == IDLE) || last;
        cand_if   = if_req  && (state_q != BUSY_IF);
        cand_mem  = mem_req && (state_q != BUSY_MEM);
        grant_if  = arb && cand_if && (!cand_mem || (starve_q == STARVE_LIM));
        grant_mem = arb && cand_mem && !grant_if;
        conflict  = arb && cand_if && cand_mem;
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        rw_d        = rw_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;

        if ((state_q != IDLE) && last) begin
            if (state_q == BUSY_IF) begin
                if_ack_d   = 1'b1;
                if_rdata_d = ram_DO;
            end else begin
                mem_ack_d = 1'b1;
                if (rw_q == RW_READ) begin
                    mem_rdata_d = ram_DO;
                end
            end
        end

        // Fetches carry no store data; zero keeps ram_DI deterministic during IF reads.
        if (arb) begin
            if (grant_if) begin
                state_d  = BUSY_IF;
                starve_d = 3'd0;
                addr_d   = if_addr;
                rw_d     = RW_READ;
                size_d   = SIZE_WORD;
                wdata_d  = '0;
            end else if (grant_mem) begin
                state_d = BUSY_MEM;
                addr_d  = mem_addr;
                rw_d    = mem_rw;
                size_d  = mem_size;
                wdata_d = mem_wdata;
                if (cand_if && (starve_q != STARVE_LIM)) begin
                    starve_d = starve_q + 3'd1;
                end
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q     <= IDLE;
            starve_q    <= 3'd0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            rw_q        <= 1'b0;
            size_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            rw_q        <= rw_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign mem_ack   = mem_ack_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign stall_if  = if_req  & ~if_ack_q;
    assign stall_mem = mem_req & ~mem_ack_q;
    assign ram_E     = (state_q != IDLE);
    assign ram_RW    = rw_q;
    assign ram_Size  = size_q;
    assign ram_A     = addr_q;
    assign ram_DI    = wdata_q;

`ifdef PPU_ARB_STATS_EN
    logic [15:0] if_cnt_q, if_cnt_d, mem_cnt_q, mem_cnt_d, conf_cnt_q, conf_cnt_d;

    always_comb begin
        if_cnt_d   = if_cnt_q;
        mem_cnt_d  = mem_cnt_q;
        conf_cnt_d = conf_cnt_q;
        if (grant_if && (if_cnt_q != 16'hFFFF)) begin
            if_cnt_d = if_cnt_q + 16'd1;
        end
        if (grant_mem && (mem_cnt_q != 16'hFFFF)) begin
            mem_cnt_d = mem_cnt_q + 16'd1;
        end
        if (conflict && (conf_cnt_q != 16'hFFFF)) begin
            conf_cnt_d = conf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            if_cnt_q   <= 16'd0;
            mem_cnt_q  <= 16'd0;
            conf_cnt_q <= 16'd0;
        end else begin
            if_cnt_q   <= if_cnt_d;
            mem_cnt_q  <= mem_cnt_d;
            conf_cnt_q <= conf_cnt_d;
        end
    end

    assign if_grant_cnt  = if_cnt_q;
    assign mem_grant_cnt = mem_cnt_q;
    assign conflict_cnt  = conf_cnt_q;
`endif

endmodule
